// File: rtl/micro_seq_pkg.sv
// Shared definitions for the micro-step sequencer: FSM encoding, register ids
// and the helpers that turn a captured register id into a one-hot load strobe.
package micro_seq_pkg;

  localparam int unsigned MAX_STEPS = 3;

  localparam logic [3:0] REG_ESP = 4'h1;
  localparam logic [3:0] REG_EBP = 4'h2;
  localparam logic [3:0] REG_EAX = 4'h3;
  localparam logic [3:0] REG_EIP = 4'h4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STEP1 = 3'd1,
    ST_STEP2 = 3'd2,
    ST_STEP3 = 3'd3,
    ST_ADV   = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Instruction fields held for the whole sequence once accepted.
  typedef struct packed {
    logic [3:0] reg_load_1;
    logic [3:0] reg_load_2;
    logic [3:0] reg_load_3;
    logic [3:0] select_1;
    logic [3:0] select_2;
    logic [3:0] select_3;
    logic [3:0] num_of_ope;
  } ope_fields_t;

  function automatic logic step_valid(input logic [3:0] reg_id);
    return (reg_id >= REG_ESP) && (reg_id <= REG_EIP);
  endfunction

  function automatic logic [3:0] reg_onehot(input logic [3:0] reg_id);
    case (reg_id)
      REG_ESP: return 4'b0001;
      REG_EBP: return 4'b0010;
      REG_EAX: return 4'b0100;
      REG_EIP: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/micro_seq.sv
// Micro-step sequencer: accepts one decoded instruction, plays out up to three
// register-load steps, then issues a single eip advance. Outputs are Moore-decoded.
module micro_seq
  import micro_seq_pkg::*;
(
  input  logic       clk2,
  input  logic       reset_n,
  input  logic       ope_valid,
  output logic       ope_ready,
  input  logic [3:0] reg_load_1,
  input  logic [3:0] reg_load_2,
  input  logic [3:0] reg_load_3,
  input  logic [3:0] select_1,
  input  logic [3:0] select_2,
  input  logic [3:0] select_3,
  input  logic [3:0] num_of_ope,
  output logic [3:0] alu_sel,
  output logic [3:0] load_en,
  output logic       eip_inc_en,
  output logic [3:0] eip_inc,
  output logic [1:0] step_idx,
  output logic       illegal
);

  state_t      r_state;
  state_t      w_next_state;
  ope_fields_t r_fields;
  logic        w_accept;

  assign w_accept = ope_valid && (r_state == ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // NOTE: the capture registers are few and feed outputs directly, so they
  // are reset to keep a post-reset sequence free of stale fields.
  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) begin
      r_fields <= '0;
    end else if (w_accept) begin
      r_fields <= '{reg_load_1: reg_load_1, reg_load_2: reg_load_2,
                    reg_load_3: reg_load_3, select_1: select_1,
                    select_2: select_2, select_3: select_3,
                    num_of_ope: num_of_ope};
    end
  end

  // NOTE: defaults first in every combinational process so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ope_valid) begin
          w_next_state = (step_valid(reg_load_1) && (num_of_ope != 4'd0))
                         ? ST_STEP1 : ST_ERR;
        end
      end
      ST_STEP1: w_next_state = step_valid(r_fields.reg_load_2) ? ST_STEP2 : ST_ADV;
      ST_STEP2: w_next_state = step_valid(r_fields.reg_load_3) ? ST_STEP3 : ST_ADV;
      ST_STEP3: w_next_state = ST_ADV;
      ST_ADV:   w_next_state = ST_IDLE;
      ST_ERR:   w_next_state = ST_ERR;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ope_ready  = 1'b0;
    alu_sel    = 4'd0;
    load_en    = 4'd0;
    eip_inc_en = 1'b0;
    eip_inc    = 4'd0;
    step_idx   = 2'd0;
    illegal    = 1'b0;
    case (r_state)
      ST_IDLE: ope_ready = 1'b1;
      ST_STEP1: begin
        alu_sel  = r_fields.select_1;
        load_en  = reg_onehot(r_fields.reg_load_1);
        step_idx = 2'd1;
      end
      ST_STEP2: begin
        alu_sel  = r_fields.select_2;
        load_en  = reg_onehot(r_fields.reg_load_2);
        step_idx = 2'd2;
      end
      ST_STEP3: begin
        alu_sel  = r_fields.select_3;
        load_en  = reg_onehot(r_fields.reg_load_3);
        step_idx = 2'(MAX_STEPS);
      end
      ST_ADV: begin
        eip_inc_en = 1'b1;
        eip_inc    = r_fields.num_of_ope;
      end
      ST_ERR:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_micro_seq.sv
// Directed bench for micro_seq: fixed instruction vectors with hand-derived
// cycle-by-cycle expectations, checked 1 ns after each rising edge.
module tb_micro_seq;

  logic       clk2 = 1'b0;
  logic       reset_n;
  logic       ope_valid;
  logic       ope_ready;
  logic [3:0] reg_load_1, reg_load_2, reg_load_3;
  logic [3:0] select_1, select_2, select_3;
  logic [3:0] num_of_ope;
  logic [3:0] alu_sel;
  logic [3:0] load_en;
  logic       eip_inc_en;
  logic [3:0] eip_inc;
  logic [1:0] step_idx;
  logic       illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk2 = ~clk2;

  micro_seq dut (
    .clk2       (clk2),
    .reset_n    (reset_n),
    .ope_valid  (ope_valid),
    .ope_ready  (ope_ready),
    .reg_load_1 (reg_load_1),
    .reg_load_2 (reg_load_2),
    .reg_load_3 (reg_load_3),
    .select_1   (select_1),
    .select_2   (select_2),
    .select_3   (select_3),
    .num_of_ope (num_of_ope),
    .alu_sel    (alu_sel),
    .load_en    (load_en),
    .eip_inc_en (eip_inc_en),
    .eip_inc    (eip_inc),
    .step_idx   (step_idx),
    .illegal    (illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full output vector check: ready, alu_sel, load_en, eip_inc_en, eip_inc, step_idx, illegal.
  task automatic expect_outs(input string tag, input logic rdy, input logic [3:0] alu,
                             input logic [3:0] ld, input logic inc_en, input logic [3:0] inc,
                             input logic [1:0] idx, input logic ill);
    check({tag, ".ope_ready"},  32'(ope_ready),  32'(rdy));
    check({tag, ".alu_sel"},    32'(alu_sel),    32'(alu));
    check({tag, ".load_en"},    32'(load_en),    32'(ld));
    check({tag, ".eip_inc_en"}, 32'(eip_inc_en), 32'(inc_en));
    check({tag, ".eip_inc"},    32'(eip_inc),    32'(inc));
    check({tag, ".step_idx"},   32'(step_idx),   32'(idx));
    check({tag, ".illegal"},    32'(illegal),    32'(ill));
  endtask

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic set_fields(input logic [3:0] r1, r2, r3, s1, s2, s3, n);
    reg_load_1 = r1; reg_load_2 = r2; reg_load_3 = r3;
    select_1 = s1; select_2 = s2; select_3 = s3;
    num_of_ope = n;
  endtask

  // Offer an instruction in the current (IDLE) cycle, pass the accepting edge,
  // then scramble the inputs so any late capture would show up.
  task automatic issue(input logic [3:0] r1, r2, r3, s1, s2, s3, n);
    set_fields(r1, r2, r3, s1, s2, s3, n);
    ope_valid = 1'b1;
    tick();
    ope_valid = 1'b0;
    set_fields(4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hD);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    ope_valid = 1'b0;
    set_fields(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    // Reset: outputs idle while reset_n is low and after release.
    #3;
    expect_outs("rst_low", 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    expect_outs("rst_rel", 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0);

    // Two steps: reg_load 1/1/0, select 2/1/0, num 1.
    issue(4'h1, 4'h1, 4'h0, 4'h2, 4'h1, 4'h0, 4'h1);
    expect_outs("a.T1", 1'b0, 4'h2, 4'b0001, 1'b0, 4'h0, 2'd1, 1'b0);
    tick();
    expect_outs("a.T2", 1'b0, 4'h1, 4'b0001, 1'b0, 4'h0, 2'd2, 1'b0);
    tick();
    expect_outs("a.T3", 1'b0, 4'h0, 4'b0000, 1'b1, 4'h1, 2'd0, 1'b0);
    tick();
    expect_outs("a.T4", 1'b1, 4'h0, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0);

    // Three steps: reg_load 1/1/4, select 2/3/2, num 6.
    issue(4'h1, 4'h1, 4'h4, 4'h2, 4'h3, 4'h2, 4'h6);
    expect_outs("b.T1", 1'b0, 4'h2, 4'b0001, 1'b0, 4'h0, 2'd1, 1'b0);
    tick();
    expect_outs("b.T2", 1'b0, 4'h3, 4'b0001, 1'b0, 4'h0, 2'd2, 1'b0);
    tick();
    expect_outs("b.T3", 1'b0, 4'h2, 4'b1000, 1'b0, 4'h0, 2'd3, 1'b0);
    tick();
    expect_outs("b.T4", 1'b0, 4'h0, 4'b0000, 1'b1, 4'h6, 2'd0, 1'b0);
    tick();
    expect_outs("b.T5", 1'b1, 4'h0, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0);

    // Sequence ends at the first invalid step: reg_load 3/0/4, num 5.
    issue(4'h3, 4'h0, 4'h4, 4'h3, 4'h0, 4'h2, 4'h5);
    expect_outs("c.T1", 1'b0, 4'h3, 4'b0100, 1'b0, 4'h0, 2'd1, 1'b0);
    tick();
    expect_outs("c.T2", 1'b0, 4'h0, 4'b0000, 1'b1, 4'h5, 2'd0, 1'b0);
    tick();
    expect_outs("c.T3", 1'b1, 4'h0, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0);

    // Invalid first step: ERR is sticky and ignores further valid offers.
    issue(4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h3);
    expect_outs("d.T1", 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b1);
    ope_valid = 1'b1;
    set_fields(4'h1, 4'h2, 4'h3, 4'h1, 4'h1, 4'h1, 4'h2);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_outs($sformatf("d.hold%0d", i), 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b1);
    end
    ope_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    expect_outs("d.rst", 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0);
    reset_n = 1'b1;
    tick();
    expect_outs("d.after", 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0);

    // Zero instruction length also traps.
    issue(4'h2, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    expect_outs("e.T1", 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b1);
    tick();
    expect_outs("e.T2", 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b1);
    pulse_reset();
    expect_outs("e.after", 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0);

    // Reset during STEP2 aborts with no further strobes.
    issue(4'h1, 4'h1, 4'h4, 4'h2, 4'h3, 4'h2, 4'h6);
    tick();
    expect_outs("f.step2", 1'b0, 4'h3, 4'b0001, 1'b0, 4'h0, 2'd2, 1'b0);
    reset_n = 1'b0;
    #1;
    expect_outs("f.rst", 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_outs($sformatf("f.post%0d", i), 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0);
    end

    // ope_valid held high: one acceptance per IDLE, busy-time fields ignored.
    ope_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic [3:0] rid, sel, num, onehot;
      rid    = (t % 2 == 0) ? 4'h3 : 4'h2;
      sel    = (t % 2 == 0) ? 4'h5 : 4'h7;
      num    = (t % 2 == 0) ? 4'h2 : 4'h3;
      onehot = (t % 2 == 0) ? 4'b0100 : 4'b0010;
      check($sformatf("g%0d.ready", t), 32'(ope_ready), 32'd1);
      set_fields(rid, 4'h0, 4'h0, sel, 4'h0, 4'h0, num);
      tick();
      set_fields(4'h4, 4'h4, 4'h4, 4'h9, 4'h9, 4'h9, 4'h9);
      expect_outs($sformatf("g%0d.T1", t), 1'b0, sel, onehot, 1'b0, 4'h0, 2'd1, 1'b0);
      tick();
      expect_outs($sformatf("g%0d.T2", t), 1'b0, 4'h0, 4'h0, 1'b1, num, 2'd0, 1'b0);
      tick();
    end
    ope_valid = 1'b0;
    check("g.final_ready", 32'(ope_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_seq.md
MICRO_SEQ -- requirements
Module: micro_seq

Interface
REQ-001 The block SHALL have these ports: clk2, input, 1 bit, single clock; all state changes on its rising edge.
REQ-002 The block SHALL have: reset_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-003 The block SHALL have: ope_valid, input, 1 bit, decoded instruction fields present.
REQ-004 The block SHALL have: ope_ready, output, 1 bit, sequencer can accept a new instruction.
REQ-005 The block SHALL have: reg_load_1/2/3, inputs, 4 bits each, destination register id per micro-step.
REQ-006 The block SHALL have: select_1/2/3, inputs, 4 bits each, ALU input select per micro-step.
REQ-007 The block SHALL have: num_of_ope, input, 4 bits, instruction length in bytes.
REQ-008 The block SHALL have: alu_sel, output, 4 bits, ALU input mux select for the current step.
REQ-009 The block SHALL have: load_en, output, 4 bits, one-hot register load; bit0 esp(id 1), bit1 ebp(2), bit2 eax(3), bit3 eip(4).
REQ-010 The block SHALL have: eip_inc_en, output, 1 bit, one-cycle eip advance strobe.
REQ-011 The block SHALL have: eip_inc, output, 4 bits, amount added to eip.
REQ-012 The block SHALL have: step_idx, output, 2 bits, current step 1..3, 0 otherwise.
REQ-013 The block SHALL have: illegal, output, 1 bit, sticky error flag.

Function
REQ-014 Step k SHALL be valid iff reg_load_k is 4'h1..4'h4; the sequence ends at the first invalid step, and later steps are ignored.
REQ-015 FSM states SHALL be IDLE, STEP1, STEP2, STEP3, ADV, ERR.
REQ-016 ope_ready SHALL be 1 only in IDLE; acceptance = ope_valid && ope_ready at a rising edge.
REQ-017 On acceptance, all seven input fields SHALL be captured; inputs are don't-care afterwards until the next IDLE.
REQ-018 On acceptance, the next state SHALL be STEP1 if step 1 is valid and num_of_ope != 0; otherwise the next state is ERR.
REQ-019 In STEPk, alu_sel SHALL equal the captured select_k, load_en SHALL be onehot(captured reg_load_k), and step_idx SHALL be k, each for exactly one cycle.
REQ-020 From STEPk, the next state SHALL be STEP(k+1) if that step is valid and k<3, else ADV.
REQ-021 In ADV, eip_inc_en SHALL be 1 and eip_inc SHALL equal the captured num_of_ope for one cycle; the next state is IDLE.
REQ-022 Latency for n valid steps SHALL be: accept at T0, steps at T1..Tn, ADV at Tn+1, ope_ready=1 at Tn+2.
REQ-023 Outside STEPk, alu_sel, load_en and step_idx SHALL be 0; outside ADV, eip_inc_en and eip_inc SHALL be 0.
REQ-024 ERR SHALL set illegal=1, hold ope_ready=0 and all strobes 0, and be left only by reset.
REQ-025 ope_valid asserted while not in IDLE SHALL be ignored, with no capture and no state effect.
REQ-026 All outputs SHALL be registered, decoded from state and captured fields, with no combinational path from inputs to outputs except none.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, clear captured fields, and set illegal=0, alu_sel=0, load_en=0, eip_inc_en=0, eip_inc=0, step_idx=0, and ope_ready=1 while reset_n=0 and after release.
REQ-028 Reset mid-sequence SHALL abort the sequence without emitting any further load_en or eip_inc_en pulse.

Structure
REQ-029 Package micro_seq_pkg SHALL hold the FSM state encoding, the register ids (ESP=1, EBP=2, EAX=3, EIP=4), MAX_STEPS=3, and the reg-id-to-one-hot function.
REQ-030 No sub-module SHALL be used; the block is one FSM plus capture registers.

Verification
REQ-031 The bench SHALL drive reg_load=1/1/0, select=2/1/0, num=1 and SHALL check: T1 alu_sel=2 load_en=0001; T2 alu_sel=1 load_en=0001; T3 eip_inc_en=1 eip_inc=1; T4 ope_ready=1.
REQ-032 The bench SHALL drive reg_load=1/1/4, select=2/3/2, num=6 and SHALL check: steps T1..T3 with load_en=0001,0001,1000; T4 eip_inc=6.
REQ-033 The bench SHALL drive reg_load=3/0/4, select=3/0/2, num=5 and SHALL check: one step (load_en=0100, alu_sel=3); step 3 ignored; T2 eip_inc=5.
REQ-034 The bench SHALL drive reg_load_1=0 (and separately num=0) and SHALL check: illegal=1 at T1, no load_en or eip_inc_en, and ope_ready stuck at 0 until reset_n pulse, which clears illegal.
REQ-035 The bench SHALL assert reset_n=0 during STEP2 of the REQ-032 case and SHALL check: outputs 0 at once, no ADV pulse, and ope_ready=1 after release.
REQ-036 The bench SHALL hold ope_valid=1 continuously with alternating field sets and SHALL check: each accepted exactly once per IDLE, and none captured while busy.
